ram_rd_stream: RTL
==================

Name: ram_rd_stream

Overview:
- Read-side streaming engine for the dual-port block RAMs used across the shell; drives the read-only port B of a RAM with a registered read (1-cycle latency).
- Accepts a (start address, length) request and streams consecutive words out on a valid/ready master interface, with full backpressure support.
- Sustains 1 word/cycle when the sink is always ready; a 2-entry output buffer absorbs RAM latency so no word is dropped or duplicated.

Parameters:
- ADDR_BITS, 10, RAM address width; depth = 2**ADDR_BITS
- DATA_BITS, 64, RAM word / stream data width
- LEN_BITS, ADDR_BITS+1, request length width; max length = 2**ADDR_BITS words

Ports:
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_addr  in  ADDR_BITS  first word address
- req_len  in  LEN_BITS  number of words; 0 = no-op
- ram_en  out  1  RAM read enable (to port B enable)
- ram_addr  out  ADDR_BITS  RAM read address (to port B address)
- ram_data  in  DATA_BITS  RAM read data, valid the cycle after ram_en
- m_valid  out  1  output word valid
- m_ready  in  1  sink ready
- m_data  out  DATA_BITS  output word
- m_last  out  1  marks final word of the request
- busy  out  1  high while a request is in progress

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high.
- Reset values: req_ready=0 while rst is high, then 1 (IDLE). ram_en=0, ram_addr=0, m_valid=0, m_data=0, m_last=0, busy=0.
- States: IDLE, READ, DRAIN. busy = (state != IDLE). req_ready = (state == IDLE) & !rst.
- IDLE:
  - On a request handshake with req_len != 0: latch addr and remaining = req_len, go to READ.
  - With req_len == 0: handshake completes, stay IDLE, no RAM access, no output.
- READ: issue a read (ram_en=1, ram_addr=current addr) in any cycle where occ + inflight - (m_valid & m_ready) < 2.
  - occ = buffer entries (0..2); inflight = read issued the previous cycle (0/1).
  - Each issue: addr <= addr + 1, wrapping modulo 2**ADDR_BITS (1023 -> 0 for ADDR_BITS=10); remaining <= remaining - 1.
  - When the last read is issued, go to DRAIN.
- DRAIN: no further ram_en. Return to IDLE in the cycle after the handshake of the word with m_last=1.
- Data capture: ram_data is written into the buffer at the clock edge ending the cycle after ram_en; capture is unconditional because credits guarantee space.
- Buffer: 2-entry FIFO.
  - m_valid = occ != 0; m_data/m_last come from the head entry.
  - m_last is tagged on the capture of the final issued read.
- Stream rules:
  - m_data and m_last are held stable while m_valid & !m_ready.
  - m_valid is never withdrawn without a handshake.
  - Words are output in address order.
- Latency:
  - Request handshake in cycle 0 -> first ram_en in cycle 1 -> first m_valid in cycle 3.
  - With m_ready held at 1, one word per cycle thereafter.
- Simultaneous capture and pop in one cycle: occ unchanged; FIFO ordering preserved.
- m_ready low with buffer full: ram_en stays 0 until a pop; no word is lost.
- req_valid while busy is ignored (req_ready=0); the request fields are not sampled.
- Reset mid-burst: state returns to IDLE immediately, buffer and inflight are cleared, the pending RAM read result is discarded, and all outputs take their reset values.

Test Plan:
- req_addr=5, req_len=4, m_ready=1 -> ram_en cycles 1-4 with addr 5,6,7,8; m_valid cycles 3-6 carrying mem[5..8]; m_last only in cycle 6; req_ready=1 again in cycle 7.
- Wrap-around (ADDR_BITS=10): req_addr=1022, req_len=4 -> ram_addr sequence 1022, 1023, 0, 1; output mem[1022], mem[1023], mem[0], mem[1]; m_last on mem[1].
- Backpressure: req_addr=0, req_len=8, m_ready pattern 1,0,0,1,0,1,... -> exactly 8 words mem[0..7] in order, no duplicates; m_data stable while stalled; occ + inflight never exceeds 2.
- req_len=0 -> handshake completes in one cycle; ram_en and m_valid stay 0; busy stays 0; req_ready remains 1.
- Assert rst after 2 of 6 words are handshaked -> all outputs 0 during reset; after release, req_addr=9, req_len=1 yields exactly one word mem[9] with m_last=1, with no stale data from the aborted burst.
- Full depth: req_addr=0, req_len=1024, m_ready=1 -> 1024 consecutive words with no bubbles after the first; m_last on mem[1023]; busy low the cycle after.

Source files
------------

// File: rtl/ram_rd_stream_if.sv
// Bundle of the request, RAM port-B and output-stream signals of ram_rd_stream.
//   req_*  : request channel (start address, length), valid/ready
//   ram_*  : read-only RAM port B (enable, address, registered read data)
//   m_*    : output word stream, valid/ready, with end-of-request marker
//   busy   : engine status
// modport master: the streaming engine side. modport slave: its environment.
interface ram_rd_stream_if #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned DATA_BITS = 64,
  parameter int unsigned LEN_BITS  = ADDR_BITS + 1
);
  logic                 req_valid;
  logic                 req_ready;
  logic [ADDR_BITS-1:0] req_addr;
  logic [LEN_BITS-1:0]  req_len;

  logic                 ram_en;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [DATA_BITS-1:0] ram_data;

  logic                 m_valid;
  logic                 m_ready;
  logic [DATA_BITS-1:0] m_data;
  logic                 m_last;

  logic                 busy;

  modport master (
    input  req_valid, req_addr, req_len, ram_data, m_ready,
    output req_ready, ram_en, ram_addr, m_valid, m_data, m_last, busy
  );

  modport slave (
    output req_valid, req_addr, req_len, ram_data, m_ready,
    input  req_ready, ram_en, ram_addr, m_valid, m_data, m_last, busy
  );
endinterface

// File: rtl/ram_rd_stream.sv
// Read-side streaming engine for a dual-port block RAM (port B, 1-cycle registered read).
// Accepts a (start address, length) request and streams the words out in address order
// on a valid/ready interface with full backpressure. A 2-entry buffer plus credit
// accounting (buffered + in-flight reads) sustains one word per cycle.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : ram_rd_stream_if.master (request, RAM port B, output stream, busy)
module ram_rd_stream #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned DATA_BITS = 64,
  parameter int unsigned LEN_BITS  = ADDR_BITS + 1
) (
  input logic           clk,
  input logic           rst,
  ram_rd_stream_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [LEN_BITS-1:0]  remain_q, remain_d;
  logic                 inflight_q;
  logic                 inflight_last_q;

  logic [DATA_BITS-1:0] buf_data_q [2];
  logic                 buf_last_q [2];
  logic                 rd_ptr_q, wr_ptr_q;
  logic [1:0]           occ_q, occ_d;

  logic req_fire;
  logic start;
  logic push;
  logic pop;
  logic credit_ok;
  logic issue;
  logic last_issue;
  logic head_last;

  assign req_fire   = bus.req_valid & bus.req_ready;
  assign start      = req_fire & (bus.req_len != '0);
  // A read issued last cycle lands in the buffer at this edge.
  assign push       = inflight_q;
  assign pop        = (occ_q != 2'd0) & bus.m_ready;
  // Only issue while buffered + in-flight words, net of this cycle's pop, leave a free slot.
  assign credit_ok  = (3'(occ_q) + 3'(inflight_q) - 3'(pop)) < 3'd2;
  assign issue      = (state_q == StRead) & credit_ok;
  assign last_issue = issue & (remain_q == LEN_BITS'(1));
  assign head_last  = buf_last_q[rd_ptr_q];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRead;
      StRead:  if (last_issue) state_d = StDrain;
      StDrain: if (pop & head_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.req_ready = (state_q == StIdle) & ~rst;
    bus.busy      = (state_q != StIdle);
    bus.ram_en    = issue;
    bus.ram_addr  = issue ? addr_q : '0;
  end

  // Address / remaining-length counters and buffer occupancy
  always_comb begin
    addr_d   = addr_q;
    remain_d = remain_q;
    if (start) begin
      addr_d   = bus.req_addr;
      remain_d = bus.req_len;
    end else if (issue) begin
      addr_d   = addr_q + ADDR_BITS'(1);  // wraps modulo RAM depth
      remain_d = remain_q - LEN_BITS'(1);
    end
    occ_d = occ_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q          <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      occ_q           <= 2'd0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_last_q[i] <= 1'b0;
      end
    end else begin
      addr_q          <= addr_d;
      remain_q        <= remain_d;
      inflight_q      <= issue;
      inflight_last_q <= last_issue;
      occ_q           <= occ_d;
      // Unconditional capture: credits guarantee a free slot.
      if (push) begin
        buf_data_q[wr_ptr_q] <= bus.ram_data;
        buf_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Output stream from buffer head
  always_comb begin
    bus.m_valid = (occ_q != 2'd0);
    bus.m_data  = buf_data_q[rd_ptr_q];
    bus.m_last  = head_last & (occ_q != 2'd0);
  end

endmodule
